// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch controller.
//
// Drives the PC register's next value (pc_new) and reads its current value (pc_old).
// The instruction at pc_old is fetched over a req/ack memory handshake and offered
// to decode over a valid/ready handshake. The PC steps by PC_STEP, redirects on a
// taken branch and holds otherwise. A request that goes MAX_WAIT cycles without ack
// raises a sticky fetch error.
//
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   pc_old / pc_new             PC register output / next-PC (combinational)
//   imem_req/addr/ack/rdata     instruction-memory handshake
//   instr_valid/instr/ready     decode handshake
//   stall                       blocks the PC advance while an instruction is held
//   branch_taken/branch_target  redirect pulse and address (bit 0 ignored)
//   fetch_err                   sticky memory-timeout flag
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] pc_old,
    output logic [15:0] pc_new,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        fetch_err
);

    // Counter holds the number of ack-less cycles already spent, 0..MAX_WAIT-1.
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CntW-1:0] LastWait = CntW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHold,
        StFlush,
        StErr
    } state_e;

    state_e          state_q;
    logic            imem_req_q;
    logic [15:0]     imem_addr_q;
    logic            instr_valid_q;
    logic [15:0]     instr_q;
    logic            fetch_err_q;
    logic [CntW-1:0] wait_cnt_q;

    logic [15:0] tgt;
    logic [15:0] step_pc;
    logic        advance;
    logic        timeout;

    assign tgt     = {branch_target[15:1], 1'b0};
    assign step_pc = pc_old + 16'(PC_STEP);
    assign advance = instr_ready && !stall;
    // Only meaningful while a request is outstanding (REQ/FLUSH).
    assign timeout = !imem_ack && (wait_cnt_q == LastWait);

    // The PC register loads every edge, so every path not moving the PC must echo pc_old.
    always_comb begin
        pc_new = pc_old;
        if (!reset_n) begin
            pc_new = RESET_PC;
        end else begin
            case (state_q)
                StIdle:         pc_new = branch_taken ? tgt : RESET_PC;
                StReq, StFlush: if (branch_taken) pc_new = tgt;
                StHold: begin
                    if (branch_taken) begin
                        pc_new = tgt;
                    end else if (advance) begin
                        pc_new = step_pc;
                    end
                end
                default:        pc_new = pc_old;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 16'h0000;
            instr_valid_q <= 1'b0;
            instr_q       <= 16'h0000;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    imem_req_q    <= 1'b1;
                    imem_addr_q   <= pc_new;
                    instr_valid_q <= 1'b0;
                    wait_cnt_q    <= '0;
                    state_q       <= StReq;
                end
                StReq: begin
                    if (imem_ack) begin
                        wait_cnt_q <= '0;
                        if (branch_taken) begin
                            // Data is for the old path; re-request at the target.
                            imem_addr_q <= tgt;
                        end else begin
                            instr_q       <= imem_rdata;
                            instr_valid_q <= 1'b1;
                            imem_req_q    <= 1'b0;
                            state_q       <= StHold;
                        end
                    end else if (timeout) begin
                        fetch_err_q   <= 1'b1;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b0;
                        state_q       <= StErr;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                        // The request cannot be withdrawn; let it finish, then drop it.
                        if (branch_taken) state_q <= StFlush;
                    end
                end
                StHold: begin
                    if (branch_taken || advance) begin
                        instr_valid_q <= 1'b0;
                        imem_addr_q   <= pc_new;
                        imem_req_q    <= 1'b1;
                        state_q       <= StReq;
                    end
                end
                StFlush: begin
                    if (imem_ack) begin
                        wait_cnt_q  <= '0;
                        // pc_new rather than pc_old so a branch in this very cycle
                        // is fetched from its own target.
                        imem_addr_q <= pc_new;
                        state_q     <= StReq;
                    end else if (timeout) begin
                        fetch_err_q   <= 1'b1;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b0;
                        state_q       <= StErr;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
                end
                StErr: begin
                    state_q <= StErr;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: bench for fetch_sequencer.
//
// Contains the PC register (pc_old <= pc_new every edge), an instruction-memory
// responder, a transaction-level reference model checked on every falling edge,
// directed scenarios with literal expectations, and randomized traffic.
module tb_fetch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int unsigned PC_STEP  = 2;
    localparam int unsigned MAX_WAIT = 15;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] pc_old;
    logic [15:0] pc_new;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;  // 0: ack whenever requested, 1: random, 2: never
    int ack_pct = 70;

    fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .PC_STEP (PC_STEP),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pc_old       (pc_old),
        .pc_new       (pc_new),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_err    (fetch_err)
    );

    always #5 clock = ~clock;

    // PC register: no enable, loads every rising edge.
    always @(posedge clock) pc_old <= pc_new;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the outstanding memory request, whether its data is
    // to be dropped, and the instruction held for decode.
    logic        m_started, m_err, m_wait, m_have, m_discard;
    logic [15:0] m_addr, m_instr, m_pc, m_tgt;
    int          m_cnt;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_pc_new", pc_new, RESET_PC);
            chk("rst_req", 16'(imem_req), 16'h0);
            chk("rst_valid", 16'(instr_valid), 16'h0);
            chk("rst_err", 16'(fetch_err), 16'h0);
            chk("rst_addr", imem_addr, 16'h0);
            chk("rst_instr", instr, 16'h0);
            m_started = 1'b0;
            m_err     = 1'b0;
            m_wait    = 1'b0;
            m_have    = 1'b0;
            m_discard = 1'b0;
            m_cnt     = 0;
        end else begin
            m_tgt = {branch_target[15:1], 1'b0};
            chk("m_req", 16'(imem_req), 16'(m_wait));
            chk("m_valid", 16'(instr_valid), 16'(m_have));
            chk("m_err", 16'(fetch_err), 16'(m_err));
            if (m_wait) chk("m_addr", imem_addr, m_addr);
            if (m_have) chk("m_instr", instr, m_instr);
            m_pc = pc_old;
            if (!m_started) begin
                m_pc      = branch_taken ? m_tgt : RESET_PC;
                m_started = 1'b1;
                m_wait    = 1'b1;
                m_addr    = m_pc;
                m_cnt     = 0;
            end else if (m_err) begin
                m_pc = pc_old;
            end else if (m_wait) begin
                if (branch_taken) m_pc = m_tgt;
                if (imem_ack) begin
                    m_cnt = 0;
                    if (m_discard || branch_taken) begin
                        m_addr    = m_pc;
                        m_discard = 1'b0;
                    end else begin
                        m_instr = imem_rdata;
                        m_have  = 1'b1;
                        m_wait  = 1'b0;
                    end
                end else if (m_cnt == int'(MAX_WAIT) - 1) begin
                    m_err  = 1'b1;
                    m_wait = 1'b0;
                    m_have = 1'b0;
                end else begin
                    m_cnt++;
                    if (branch_taken) m_discard = 1'b1;
                end
            end else if (branch_taken || (instr_ready && !stall)) begin
                m_pc   = branch_taken ? m_tgt : pc_old + 16'(PC_STEP);
                m_have = 1'b0;
                m_wait = 1'b1;
                m_addr = m_pc;
            end
            chk("m_pc_new", pc_new, m_pc);
        end
    end

    // One cycle: drive just after the rising edge, default branch low, memory responds.
    task automatic tick();
        @(posedge clock);
        #1;
        branch_taken = 1'b0;
        case (ack_mode)
            0:       imem_ack = imem_req;
            1:       imem_ack = (int'($urandom_range(99)) < ack_pct);
            default: imem_ack = 1'b0;
        endcase
        if (ack_mode == 1) imem_rdata = 16'($urandom);
        else imem_rdata = imem_ack ? 16'hA000 + imem_addr : 16'($urandom);
    endtask

    task automatic wait_hold(input string name);
        int n = 0;
        while (!(instr_valid && !imem_req) && n < 20) begin
            tick();
            n++;
        end
        chk(name, 16'(n < 20), 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p0, i0;
        #1 reset_n = 1'b0;
        ack_mode    = 0;
        instr_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;

        // Zero-wait streaming from reset: IDLE, then REQ/HOLD alternating.
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            if (c % 2 == 1) begin
                chk("a_req", 16'(imem_req), 16'h1);
                chk("a_addr", imem_addr, 16'(c - 1));
                chk("a_valid_lo", 16'(instr_valid), 16'h0);
            end else begin
                chk("a_req_lo", 16'(imem_req), 16'h0);
                chk("a_valid", 16'(instr_valid), 16'(c >= 2));
                if (c >= 2) chk("a_instr", instr, 16'hA000 + 16'(c - 2));
            end
            tick();
        end

        // Branch to FFFF (-> FFFE), then wraparound advance to 0000.
        wait_hold("b_hold");
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        @(negedge clock);
        chk("b_pc_tgt", pc_new, 16'hFFFE);
        tick();
        @(negedge clock);
        chk("b_addr_tgt", imem_addr, 16'hFFFE);
        tick();
        @(negedge clock);
        chk("b_instr", instr, 16'h9FFE);
        chk("b_pc_wrap", pc_new, 16'h0000);
        tick();
        @(negedge clock);
        chk("b_addr_wrap", imem_addr, 16'h0000);

        // Stall for 5 cycles in HOLD.
        wait_hold("c_hold");
        p0    = pc_old;
        i0    = instr;
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("c_pc_hold", pc_new, p0);
            chk("c_instr_hold", instr, i0);
            tick();
        end
        stall = 1'b0;
        @(negedge clock);
        chk("c_pc_adv", pc_new, 16'h0002);
        tick();

        // Branch while a request waits; old data arrives 3 cycles later.
        ack_mode      = 2;
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0041;
        @(negedge clock);
        chk("d_pc_tgt", pc_new, 16'h0040);
        chk("d_addr_old", imem_addr, 16'h0002);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'hDEAD;
            end
            @(negedge clock);
            chk("d_valid_lo", 16'(instr_valid), 16'h0);
            chk("d_addr_keep", imem_addr, 16'h0002);
        end
        ack_mode = 0;
        tick();
        @(negedge clock);
        chk("d_addr_new", imem_addr, 16'h0040);
        chk("d_valid_lo2", 16'(instr_valid), 16'h0);
        tick();
        @(negedge clock);
        chk("d_instr", instr, 16'hA040);

        // Branch in the same cycle as the ack.
        tick();
        branch_taken  = 1'b1;
        branch_target = 16'h1234;
        @(negedge clock);
        chk("e_ack_now", 16'(imem_ack && imem_req), 16'h1);
        chk("e_pc_tgt", pc_new, 16'h1234);
        tick();
        @(negedge clock);
        chk("e_addr", imem_addr, 16'h1234);
        chk("e_valid_lo", 16'(instr_valid), 16'h0);
        tick();
        @(negedge clock);
        chk("e_instr", instr, 16'hB234);

        // Timeout: 15 ack-less cycles.
        ack_mode = 2;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            @(negedge clock);
        end
        chk("f_err_pre", 16'(fetch_err), 16'h0);
        tick();
        branch_taken  = 1'b1;
        branch_target = 16'h0100;
        @(negedge clock);
        chk("f_err", 16'(fetch_err), 16'h1);
        chk("f_req", 16'(imem_req), 16'h0);
        chk("f_pc_hold", pc_new, 16'h0000);
        tick();
        #2 reset_n = 1'b0;
        #1 chk("f_async_err", 16'(fetch_err), 16'h0);
        tick();

        // Ack in the 15th cycle is accepted.
        reset_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 15) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'h5A5A;
            end
            @(negedge clock);
        end
        tick();
        @(negedge clock);
        chk("g_valid", 16'(instr_valid), 16'h1);
        chk("g_err", 16'(fetch_err), 16'h0);
        chk("g_instr", instr, 16'h5A5A);

        // Reset in the middle of a request drops it at once.
        tick();
        chk("h_req_pre", 16'(imem_req), 16'h1);
        #2 reset_n = 1'b0;
        #1 chk("h_req_async", 16'(imem_req), 16'h0);
        tick();
        reset_n = 1'b1;

        // Random traffic: mostly-responsive memory, then a slow one that can time out.
        ack_mode = 1;
        ack_pct  = 70;
        for (int phase = 0; phase < 2; phase++) begin
            for (int k = 0; k < (phase == 0 ? 3000 : 500); k++) begin
                tick();
                instr_ready = ($urandom_range(3) != 0);
                stall       = ($urandom_range(3) == 0);
                if ($urandom_range(9) == 0) begin
                    branch_taken  = 1'b1;
                    branch_target = 16'($urandom);
                end
            end
            tick();
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            ack_pct = 25;
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
